// File: rtl/pcpi_muldiv_unit.sv
// rtl/pcpi_muldiv_unit.sv - PCPI coprocessor: RV32/64 M-extension multiply/divide plus modular add/sub
// Multiply is a single registered product, divide is iterative restoring on magnitudes.
module pcpi_muldiv_unit #(
   parameter int              XLEN      = 32,
   parameter int              DIV_STEP  = 1,
   parameter logic [XLEN-1:0] MOD_RESET = '0
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            pcpi_valid,
   input  logic [31:0]     pcpi_insn,
   input  logic [XLEN-1:0] pcpi_rs1,
   input  logic [XLEN-1:0] pcpi_rs2,
   output logic [XLEN-1:0] pcpi_rd,
   output logic            pcpi_wr,
   output logic            pcpi_ready,
   output logic            pcpi_busy
);
   localparam int NSTEPS = XLEN / DIV_STEP;
   localparam int CW     = $clog2(NSTEPS) + 1;

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_MOD, S_DONE} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [2:0]        f3_q;
   logic [XLEN-1:0]   op_a, op_b, quo_q, dvs_q, mod_q;
   logic [XLEN:0]     rem_q;
   logic              neg_q, neg_r, hold_off;

   logic [2:0]        f3;
   logic              is_m, is_custom, accept;
   logic              div_signed, rs1_neg, rs2_neg, div_zero, div_ovf;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic              unused_insn_bits;

   assign f3        = pcpi_insn[14:12];
   assign is_m      = pcpi_insn[6:0] == 7'b0110011 && pcpi_insn[31:25] == 7'b0000001;
   assign is_custom = pcpi_insn[6:0] == 7'b0001011 && pcpi_insn[31:25] == 7'b0000000 &&
                      !f3[2] && f3[1:0] != 2'b11;
   assign accept    = state == S_IDLE && pcpi_valid && (is_m || is_custom) && !hold_off;
   assign unused_insn_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

   assign div_signed = !f3[0];
   assign rs1_neg    = div_signed && pcpi_rs1[XLEN-1];
   assign rs2_neg    = div_signed && pcpi_rs2[XLEN-1];
   assign a_mag      = rs1_neg ? -pcpi_rs1 : pcpi_rs1;
   assign b_mag      = rs2_neg ? -pcpi_rs2 : pcpi_rs2;
   assign div_zero   = pcpi_rs2 == '0;
   assign div_ovf    = div_signed && pcpi_rs1 == {1'b1, {(XLEN-1){1'b0}}} && pcpi_rs2 == '1;

   // Sign-extend each operand per RISC-V signedness; the low half of MUL is sign-agnostic.
   logic              a_sgn, b_sgn;
   logic [2*XLEN-1:0] prod;
   assign a_sgn = f3_q[1:0] != 2'b11 && op_a[XLEN-1];
   assign b_sgn = !f3_q[1] && op_b[XLEN-1];
   assign prod  = {{XLEN{a_sgn}}, op_a} * {{XLEN{b_sgn}}, op_b};

   logic [XLEN:0]   r_nxt;
   logic [XLEN-1:0] q_nxt, div_res;
   always_comb begin
      r_nxt = rem_q;
      q_nxt = quo_q;
      for (int i = 0; i < DIV_STEP; i++) begin
         r_nxt = {r_nxt[XLEN-1:0], q_nxt[XLEN-1]};
         q_nxt = {q_nxt[XLEN-2:0], 1'b0};
         if (r_nxt >= {1'b0, dvs_q}) begin
            r_nxt    = r_nxt - {1'b0, dvs_q};
            q_nxt[0] = 1'b1;
         end
      end
      if (f3_q[1])
         div_res = neg_r ? -r_nxt[XLEN-1:0] : r_nxt[XLEN-1:0];
      else
         div_res = neg_q ? -q_nxt : q_nxt;
   end

   // With a zero modulus both corrections vanish, leaving plain wrapping arithmetic.
   logic [XLEN:0]   add_s;
   logic [XLEN-1:0] add_res, sub_res;
   assign add_s   = {1'b0, op_a} + {1'b0, op_b};
   assign add_res = (add_s >= {1'b0, mod_q}) ? add_s[XLEN-1:0] - mod_q : add_s[XLEN-1:0];
   assign sub_res = op_a - op_b + ((op_a < op_b) ? mod_q : '0);

   assign pcpi_wr = pcpi_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         cnt        <= '0;
         f3_q       <= '0;
         op_a       <= '0;
         op_b       <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         rem_q      <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         mod_q      <= MOD_RESET;
         hold_off   <= 1'b0;
         pcpi_rd    <= '0;
         pcpi_ready <= 1'b0;
         pcpi_busy  <= 1'b0;
      end else begin
         pcpi_ready <= 1'b0;
         pcpi_rd    <= '0;
         hold_off   <= 1'b0;
         case (state)
            S_IDLE: if (accept) begin
               f3_q <= f3;
               op_a <= pcpi_rs1;
               op_b <= pcpi_rs2;
               if (is_custom && f3 == 3'b010) begin
                  mod_q      <= pcpi_rs1;
                  pcpi_rd    <= mod_q;
                  pcpi_ready <= 1'b1;
                  state      <= S_DONE;
               end else if (is_custom) begin
                  pcpi_busy <= 1'b1;
                  state     <= S_MOD;
               end else if (!f3[2]) begin
                  pcpi_busy <= 1'b1;
                  state     <= S_MUL;
               end else if (div_zero) begin
                  pcpi_rd    <= f3[1] ? pcpi_rs1 : '1;
                  pcpi_ready <= 1'b1;
                  state      <= S_DONE;
               end else if (div_ovf) begin
                  pcpi_rd    <= f3[1] ? '0 : pcpi_rs1;
                  pcpi_ready <= 1'b1;
                  state      <= S_DONE;
               end else begin
                  quo_q     <= a_mag;
                  dvs_q     <= b_mag;
                  rem_q     <= '0;
                  neg_q     <= rs1_neg ^ rs2_neg;
                  neg_r     <= rs1_neg;
                  cnt       <= CW'(NSTEPS);
                  pcpi_busy <= 1'b1;
                  state     <= S_DIV;
               end
            end
            S_MUL: begin
               pcpi_rd    <= (f3_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
               pcpi_ready <= 1'b1;
               pcpi_busy  <= 1'b0;
               state      <= S_DONE;
            end
            S_MOD: begin
               pcpi_rd    <= f3_q[0] ? sub_res : add_res;
               pcpi_ready <= 1'b1;
               pcpi_busy  <= 1'b0;
               state      <= S_DONE;
            end
            S_DIV: begin
               quo_q <= q_nxt;
               rem_q <= r_nxt;
               cnt   <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  pcpi_rd    <= div_res;
                  pcpi_ready <= 1'b1;
                  pcpi_busy  <= 1'b0;
                  state      <= S_DONE;
               end
            end
            S_DONE: begin
               hold_off <= 1'b1;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pcpi_muldiv_unit.sv
// tb/tb_pcpi_muldiv_unit.sv - scoreboard bench for pcpi_muldiv_unit (DIV_STEP 1 and 4 instances)
module tb_pcpi_muldiv_unit;
   localparam logic [6:0] OP_M = 7'b0110011;
   localparam logic [6:0] OP_C = 7'b0001011;
   localparam logic [6:0] F7_M = 7'b0000001;
   localparam logic [6:0] F7_C = 7'b0000000;

   typedef struct {
      logic [31:0] rd;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        valid [2];
   logic [31:0] insn  [2];
   logic [31:0] rs1   [2];
   logic [31:0] rs2   [2];
   logic [31:0] rd_w  [2];
   logic        wr_w  [2];
   logic        ready_w [2];
   logic        busy_w  [2];

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 0;
   exp_t q0[$];
   exp_t q1[$];

   pcpi_muldiv_unit #(.XLEN(32), .DIV_STEP(1)) dut0 (
      .clk(clk), .resetn(resetn), .pcpi_valid(valid[0]), .pcpi_insn(insn[0]),
      .pcpi_rs1(rs1[0]), .pcpi_rs2(rs2[0]), .pcpi_rd(rd_w[0]), .pcpi_wr(wr_w[0]),
      .pcpi_ready(ready_w[0]), .pcpi_busy(busy_w[0]));

   pcpi_muldiv_unit #(.XLEN(32), .DIV_STEP(4)) dut1 (
      .clk(clk), .resetn(resetn), .pcpi_valid(valid[1]), .pcpi_insn(insn[1]),
      .pcpi_rs1(rs1[1]), .pcpi_rs2(rs2[1]), .pcpi_rd(rd_w[1]), .pcpi_wr(wr_w[1]),
      .pcpi_ready(ready_w[1]), .pcpi_busy(busy_w[1]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
      return {f7, 5'd2, 5'd1, f3, 5'd3, op};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic mon(input int i);
      exp_t e;
      bit   empty;
      chk("wr_equals_ready", {63'd0, wr_w[i]}, {63'd0, ready_w[i]});
      if (ready_w[i]) begin
         empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
         if (empty) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready inst=%0d actual_rd=%0h required=no_pulse (cycle %0d)", i, rd_w[i], cyc);
         end else begin
            if (i == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk("rd", {32'd0, rd_w[i]}, {32'd0, e.rd});
            chk("ready_cycle", 64'(cyc), 64'(e.cyc));
         end
      end else begin
         chk("rd_zero_when_idle", {32'd0, rd_w[i]}, 64'd0);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0);
         mon(1);
      end
   end

   // Caller is positioned at a negedge; the following posedge is the accept edge T.
   task automatic issue(input int s, input logic [31:0] iw, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_rd, input int lat, input bit hold);
      int   t;
      int   n;
      bit   seen;
      exp_t e;
      valid[s] = 1'b1;
      insn[s]  = iw;
      rs1[s]   = a;
      rs2[s]   = b;
      t        = cyc;
      e.rd     = exp_rd;
      e.cyc    = t + lat;
      if (s == 0) q0.push_back(e);
      else        q1.push_back(e);
      n    = 0;
      seen = 0;
      while (!seen && n < 100) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            rs1[s] = $urandom;
            rs2[s] = $urandom;
            if (lat > 1) chk("busy_after_accept", {63'd0, busy_w[s]}, 64'd1);
         end
         if (ready_w[s]) begin
            seen = 1;
            chk("busy_in_ready_cycle", {63'd0, busy_w[s]}, 64'd0);
         end
      end
      chk("ready_seen", {63'd0, seen}, 64'd1);
      if (hold) begin
         @(negedge clk);
         @(negedge clk);
      end
      valid[s] = 1'b0;
      insn[s]  = '0;
      rs1[s]   = '0;
      rs2[s]   = '0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         valid[i] = 1'b0;
         insn[i]  = '0;
         rs1[i]   = '0;
         rs2[i]   = '0;
      end
      #1 resetn = 1'b0;
      #1 mon_en = 1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("reset_ready", {63'd0, ready_w[i]}, 64'd0);
         chk("reset_busy", {63'd0, busy_w[i]}, 64'd0);
         chk("reset_rd", {32'd0, rd_w[i]}, 64'd0);
      end
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      issue(0, mk(F7_M, 3'b100, OP_M), 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0);
      issue(0, mk(F7_M, 3'b110, OP_M), 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 0);
      issue(0, mk(F7_M, 3'b100, OP_M), 32'd20, 32'hFFFFFFFA, 32'hFFFFFFFD, 33, 0);
      issue(0, mk(F7_M, 3'b110, OP_M), 32'd20, 32'hFFFFFFFA, 32'd2, 33, 0);
      issue(0, mk(F7_M, 3'b101, OP_M), 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 33, 0);
      issue(0, mk(F7_M, 3'b111, OP_M), 32'd100, 32'd7, 32'd2, 33, 0);
      issue(0, mk(F7_M, 3'b001, OP_M), 32'h80000000, 32'h80000000, 32'h40000000, 2, 0);
      issue(0, mk(F7_M, 3'b010, OP_M), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 0);
      issue(0, mk(F7_M, 3'b011, OP_M), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, 0);
      issue(0, mk(F7_M, 3'b000, OP_M), 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 2, 0);
      issue(0, mk(F7_M, 3'b100, OP_M), 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
      issue(0, mk(F7_M, 3'b111, OP_M), 32'h1234, 32'd0, 32'h1234, 1, 0);
      issue(0, mk(F7_M, 3'b100, OP_M), 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
      issue(0, mk(F7_M, 3'b110, OP_M), 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 0);

      issue(0, mk(F7_C, 3'b010, OP_C), 32'd13, 32'd0, 32'd0, 1, 1);
      issue(0, mk(F7_C, 3'b000, OP_C), 32'd9, 32'd8, 32'd4, 2, 1);
      issue(0, mk(F7_C, 3'b001, OP_C), 32'd3, 32'd5, 32'd11, 2, 1);
      issue(0, mk(F7_C, 3'b010, OP_C), 32'd0, 32'd0, 32'd13, 1, 0);
      issue(0, mk(F7_C, 3'b000, OP_C), 32'hFFFFFFFF, 32'd2, 32'd1, 2, 0);
      issue(0, mk(F7_C, 3'b001, OP_C), 32'd3, 32'd5, 32'hFFFFFFFE, 2, 0);

      issue(1, mk(F7_M, 3'b101, OP_M), 32'd100, 32'd7, 32'd14, 9, 0);
      issue(1, mk(F7_M, 3'b111, OP_M), 32'd100, 32'd7, 32'd2, 9, 0);

      valid[0] = 1'b1;
      insn[0]  = mk(F7_C, 3'b011, OP_C);
      repeat (3) begin
         @(negedge clk);
         chk("unclaimed_busy", {63'd0, busy_w[0]}, 64'd0);
      end
      insn[0] = mk(7'b0000000, 3'b000, OP_M);
      repeat (3) begin
         @(negedge clk);
         chk("unclaimed_busy", {63'd0, busy_w[0]}, 64'd0);
      end
      valid[0] = 1'b0;
      @(negedge clk);

      valid[0] = 1'b1;
      insn[0]  = mk(F7_M, 3'b100, OP_M);
      rs1[0]   = 32'd1000;
      rs2[0]   = 32'd3;
      repeat (10) @(negedge clk);
      chk("div_busy_before_reset", {63'd0, busy_w[0]}, 64'd1);
      resetn   = 1'b0;
      valid[0] = 1'b0;
      #1;
      chk("abort_ready", {63'd0, ready_w[0]}, 64'd0);
      chk("abort_busy", {63'd0, busy_w[0]}, 64'd0);
      chk("abort_rd", {32'd0, rd_w[0]}, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      issue(0, mk(F7_M, 3'b000, OP_M), 32'd6, 32'd7, 32'd42, 2, 0);

      repeat (5) @(negedge clk);
      chk("scoreboard0_drained", 64'(q0.size()), 64'd0);
      chk("scoreboard1_drained", 64'(q1.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pcpi_muldiv_unit.md
PCPI_MULDIV_UNIT -- requirements
Module: pcpi_muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; legal values 32 and 64.
REQ-002 Parameter DIV_STEP, default 1: quotient bits resolved per divide cycle; legal values 1, 2 and 4; XLEN % DIV_STEP == 0.
REQ-003 Parameter MOD_RESET, default 0: reset value of the modulus register.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 resetn  input  1  asynchronous active-low reset: assertion clears all state immediately, release is synchronous to clk.
REQ-006 pcpi_valid  input  1  the core offers an instruction; held until the pcpi_ready pulse.
REQ-007 pcpi_insn  input  32  instruction word.
REQ-008 pcpi_rs1, pcpi_rs2  input  XLEN  source operands.
REQ-009 pcpi_rd  output  XLEN  result; valid only while pcpi_ready=1.
REQ-010 pcpi_wr  output  1  register write-back request; equals pcpi_ready.
REQ-011 pcpi_ready  output  1  one-cycle completion pulse.
REQ-012 pcpi_busy  output  1  accepted instruction in progress.

Function
REQ-013 Decode: opcode 0110011 with funct7 0000001 selects M ops by funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU); opcode 0001011 with funct7 0000000 selects custom ops ADDMOD (funct3 000), SUBMOD (001) and SETMOD (010); any other word is not claimed.
REQ-014 FSM states: IDLE, MUL, DIV, MOD, DONE; reset state IDLE.
REQ-015 IDLE accepts an instruction when pcpi_valid=1 and it decodes as claimed; the accept cycle is T; funct3, op class, rs1 and rs2 are latched at T; the unit never re-reads the inputs after T.
REQ-016 Unclaimed instruction: stay in IDLE; busy, ready and wr remain 0.
REQ-017 pcpi_busy=1 from T+1 up to and including the cycle before pcpi_ready; busy=0 in the ready cycle.
REQ-018 Latency L, the distance from T to the ready cycle: MUL class L=2, ADDMOD/SUBMOD L=2, SETMOD L=1, division special cases L=1, normal DIV/REM class L=XLEN/DIV_STEP+1.
REQ-019 Multiply: full 2*XLEN-bit product with operand signedness per RISC-V; MUL returns the low XLEN bits, MULH/MULHSU/MULHU return the high XLEN bits.
REQ-020 Divide: iterative restoring division on magnitudes, DIV_STEP quotient bits per cycle, with a counter of width clog2(XLEN/DIV_STEP)+1.
REQ-021 Divide signs: the quotient is negated when the operand signs differ (signed ops only); the remainder takes the sign of rs1.
REQ-022 Divide by zero: DIV/DIVU return all ones, REM/REMU return rs1; L=1.
REQ-023 Signed overflow (rs1 = most negative, rs2 = -1): DIV returns rs1, REM returns 0; L=1.
REQ-024 SETMOD: modulus register <= rs1; the result is the old modulus.
REQ-025 ADDMOD: s = rs1 + rs2 computed at XLEN+1 bits; the result is s - M when s >= M, else s[XLEN-1:0]. SUBMOD: d = rs1 - rs2; the result is d + M when rs1 < rs2 (unsigned compare), else d. Operands are assumed < M.
REQ-026 M = 0: ADDMOD and SUBMOD return plain wrapping add and subtract.
REQ-027 DONE lasts exactly one cycle and drives pcpi_ready=pcpi_wr=1 with pcpi_rd; the next state is IDLE.
REQ-028 IDLE shall not accept in the cycle immediately after the ready pulse, even if pcpi_valid is still 1; this prevents re-execution while the core is still dropping valid.
REQ-029 pcpi_valid deasserted mid-operation: the operation completes normally and the ready pulse is still issued.
REQ-030 pcpi_rd = 0 whenever pcpi_ready=0.

Reset
REQ-031 On resetn=0: state=IDLE, counter=0, operand/result registers=0, modulus=MOD_RESET, pcpi_ready=pcpi_wr=pcpi_busy=0, pcpi_rd=0.
REQ-032 Reset asserted mid-operation aborts the operation with no ready pulse; the first acceptance is possible in the first cycle after release.

Verification
REQ-033 XLEN=32, DIV_STEP=1: DIV rs1=-7, rs2=2 -> ready at T+33, rd=0xFFFFFFFD; REM of the same operands -> rd=0xFFFFFFFF.
REQ-034 DIV_STEP=4: DIVU rs1=100, rs2=7 -> ready at T+9, rd=14; REMU -> rd=2.
REQ-035 MULH rs1=0x80000000, rs2=0x80000000 -> ready at T+2, rd=0x40000000; MULHSU rs1=-1, rs2=0xFFFFFFFF -> rd=0xFFFFFFFF.
REQ-036 DIV rs2=0 -> rd=0xFFFFFFFF at T+1; DIV 0x80000000 / -1 -> rd=0x80000000; REM of the same operands -> rd=0.
REQ-037 SETMOD rs1=13 (rd = old modulus 0), then ADDMOD 9+8 -> rd=4, then SUBMOD 3-5 -> rd=11; pcpi_valid held one extra cycle after each ready -> no second ready pulse.
REQ-038 resetn pulsed low during cycle 10 of a DIV -> no ready pulse, outputs 0; a MUL issued right after release completes at T+2.
